// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB requester.
package apb_pkg;

  // Requester FSM state encoding.
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  // Protection attributes driven on the bus before the first transfer.
  localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

endpackage : apb_pkg

// File: rtl/apb_if.sv
// apb: APB4 bus-side signal bundle; masterAPB is the requester's view.
interface apb #(
  parameter int unsigned addrWidth = 32,
  parameter int unsigned dataWidth = 32
);

  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [addrWidth-1:0]   paddr;
  logic [dataWidth-1:0]   pwdata;
  logic [dataWidth/8-1:0] pstrb;
  logic [2:0]             pprot;
  logic [dataWidth-1:0]   prdata;
  logic                   pready;
  logic                   pslverr;

  modport masterAPB (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    output pstrb,
    output pprot,
    input  prdata,
    input  pready,
    input  pslverr
  );

endinterface : apb

// File: rtl/apb_master.sv
// apb_master: single-channel APB4 requester. Takes a level-based local
// request, runs SETUP/ACCESS on the bus, and returns a one-cycle completion
// pulse with read data and error status.
// Optional feature: define APB_MASTER_TIMEOUT_EN to force-complete an ACCESS
// phase that waits TIMEOUT_CYCLES cycles without pready (reported as error).
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned addrWidth      = 32,
  parameter int unsigned dataWidth      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // local request side
  input  logic                   pselxM,
  input  logic                   pwriteM,
  input  logic [addrWidth-1:0]   paddrM,
  input  logic [dataWidth-1:0]   pwdataM,
  input  logic [dataWidth/8-1:0] pstrbM,
  input  logic [2:0]             pprotM,
  output logic                   preadyM,
  output logic [dataWidth-1:0]   prdataM,
  output logic                   pslverrM,
  // APB bus side
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [addrWidth-1:0]   paddr,
  output logic [dataWidth-1:0]   pwdata,
  output logic [dataWidth/8-1:0] pstrb,
  output logic [2:0]             pprot,
  input  logic [dataWidth-1:0]   prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int unsigned StrbWidth = dataWidth / 8;

  if ((dataWidth % 8) != 0) begin : g_bad_data_width
    $error("apb_master: dataWidth must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be non-zero");
  end

  apb_state_e             state_q,    state_d;
  logic                   pwrite_q,   pwrite_d;
  logic [addrWidth-1:0]   paddr_q,    paddr_d;
  logic [dataWidth-1:0]   pwdata_q,   pwdata_d;
  logic [StrbWidth-1:0]   pstrb_q,    pstrb_d;
  logic [2:0]             pprot_q,    pprot_d;
  logic                   preadym_q,  preadym_d;
  logic [dataWidth-1:0]   prdatam_q,  prdatam_d;
  logic                   pslverrm_q, pslverrm_d;

  logic timed_out;
  logic complete;
  logic accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  // Counts ACCESS cycles already spent waiting; value k-1 during the k-th.
  logic [CntWidth-1:0] tmo_cnt_q, tmo_cnt_d;

  // Clear on SETUP, advance on each ACCESS cycle without pready.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == APB_SETUP) begin
      tmo_cnt_d = '0;
    end else if ((state_q == APB_ACCESS) && !pready) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timed_out = (state_q == APB_ACCESS) && !pready &&
                     (tmo_cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  assign complete = (state_q == APB_ACCESS) && (pready || timed_out);
  assign accept   = pselxM && ((state_q == APB_IDLE) || complete);

  // Next-state selection for the SETUP/ACCESS sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      APB_IDLE:   if (pselxM) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (complete) state_d = pselxM ? APB_SETUP : APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // Bus attributes latch only when a request is accepted; otherwise they
  // hold, which keeps them stable through ACCESS and across IDLE.
  always_comb begin
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    if (accept) begin
      pwrite_d = pwriteM;
      paddr_d  = paddrM;
      pwdata_d = pwdataM;
      pstrb_d  = pwriteM ? pstrbM : '0;
      pprot_d  = pprotM;
    end
  end

  // Local-side completion: pulse, error and read-data capture.
  always_comb begin
    preadym_d  = complete;
    pslverrm_d = complete && (timed_out || pslverr);
    prdatam_d  = prdatam_q;
    if (complete && !timed_out && !pwrite_q) begin
      prdatam_d = prdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= APB_IDLE;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pprot_q    <= APB_PPROT_DEFAULT;
      preadym_q  <= 1'b0;
      prdatam_q  <= '0;
      pslverrm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      pprot_q    <= pprot_d;
      preadym_q  <= preadym_d;
      prdatam_q  <= prdatam_d;
      pslverrm_q <= pslverrm_d;
    end
  end

  assign psel     = (state_q != APB_IDLE);
  assign penable  = (state_q == APB_ACCESS);
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pstrb    = pstrb_q;
  assign pprot    = pprot_q;
  assign preadyM  = preadym_q;
  assign prdataM  = prdatam_q;
  assign pslverrM = pslverrm_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven bench with a completer model and scoreboards
// for bus-side attributes and local-side completions.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pselxM, pwriteM;
  logic [AW-1:0] paddrM;
  logic [DW-1:0] pwdataM;
  logic [SW-1:0] pstrbM;
  logic [2:0]    pprotM;
  logic          preadyM, pslverrM;
  logic [DW-1:0] prdataM;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  apb_master #(.addrWidth(AW), .dataWidth(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .pselxM(pselxM), .pwriteM(pwriteM), .paddrM(paddrM), .pwdataM(pwdataM),
    .pstrbM(pstrbM), .pprotM(pprotM),
    .preadyM(preadyM), .prdataM(prdataM), .pslverrM(pslverrM),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int unsigned   waits;
    logic [DW-1:0] rdata;
    logic          err;
    logic [SW-1:0] exp_strb;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    int unsigned   waits;
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int unsigned   acc;
  } exp_t;

  typedef logic [AW+DW+SW+3:0] bus_t;

  resp_t       resp_q[$];
  exp_t        exp_q[$];
  bus_t        bus_q[$];
  bus_t        cur_bus = '0;
  bus_t        bus_now;
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned acc_cnt = 0;
  int unsigned acc_run = 0;
  int unsigned idle_cyc = 0;
  int unsigned pulse_cnt = 0;

  assign bus_now = {pwrite, paddr, pwdata, pstrb, pprot};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completer: answers each ACCESS phase after the queued number of waits.
  always @(negedge clk) begin
    if (!rst && psel && penable && resp_q.size() != 0) begin
      if (acc_cnt == resp_q[0].waits) begin
        pready  = 1'b1;
        prdata  = resp_q[0].rdata;
        pslverr = resp_q[0].err;
        void'(resp_q.pop_front());
        acc_cnt = 0;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
        acc_cnt++;
      end
    end else begin
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
  end

  // Monitor: completion scoreboard plus bus attribute / stability checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (preadyM) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          chk("preadyM_unexpected", preadyM, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("prdataM", prdataM, mon_e.rdata);
          chk("pslverrM", pslverrM, mon_e.err);
          chk("access_cycles", acc_run, mon_e.acc);
        end
        acc_run = 0;
      end
      if (psel && !penable) begin
        if (bus_q.size() == 0) begin
          chk("setup_unexpected", psel, 1'b0);
        end else begin
          cur_bus = bus_q.pop_front();
          chk("setup_bus", bus_now, cur_bus);
        end
      end else if (psel && penable) begin
        acc_run++;
        chk("access_bus_stable", bus_now, cur_bus);
      end else begin
        idle_cyc++;
        chk("idle_bus_hold", bus_now, cur_bus);
      end
    end
  end

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                              input logic [2:0] prot, input int unsigned waits,
                              input logic [DW-1:0] rdata, input logic err,
                              input logic [DW-1:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.waits = waits; v.rdata = rdata; v.err = err;
    v.exp_strb = wr ? strb : '0;
    v.exp_rdata = exp_rdata;
    v.exp_err = err;
    return v;
  endfunction

  // Queue expectations, present the request, wait until it reaches SETUP.
  task automatic issue(input vec_t v, input bit hold, output int unsigned lat);
    exp_t  e;
    resp_t r;
    bit    latched;
    bus_q.push_back({v.wr, v.addr, v.wdata, v.exp_strb, v.prot});
    r.waits = v.waits; r.rdata = v.rdata; r.err = v.err;
    resp_q.push_back(r);
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    e.acc = (v.waits >= TO) ? TO : v.waits + 1;
    exp_q.push_back(e);
    @(negedge clk);
    pselxM = 1'b1; pwriteM = v.wr; paddrM = v.addr; pwdataM = v.wdata;
    pstrbM = v.strb; pprotM = v.prot;
    lat = 0;
    latched = 1'b0;
    while (!latched && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (psel && !penable) latched = 1'b1;
    end
    chk("request_latched", latched, 1'b1);
    if (!hold) begin
      pselxM  = 1'b0;
      pwriteM = ~v.wr;
      paddrM  = $urandom;
      pwdataM = $urandom;
      pstrbM  = SW'($urandom);
      pprotM  = 3'($urandom);
    end
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("completion_in_budget", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    vec_t        v;
    int unsigned lat;
    int unsigned pulse0;
    int unsigned idle0;
    logic [DW-1:0] last_rd;

    //            wr    addr          wdata          strb  prot waits rdata          err   exp_strb exp_rdata      exp_err
    tbl[0] = '{1'b1, 32'h0000_0100, 32'h0000_05A5, 4'hF, 3'd0, 0, 32'h0000_0000, 1'b0, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_07FC, 32'h0000_1111, 4'hF, 3'd0, 3, 32'h0000_0123, 1'b0, 4'h0, 32'h0000_0123, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0200, 32'h0000_2222, 4'hF, 3'd2, 1, 32'hDEAD_BEEF, 1'b1, 4'h0, 32'hDEAD_BEEF, 1'b1};
    tbl[3] = '{1'b1, 32'h0000_0204, 32'h3333_4444, 4'hC, 3'd0, 0, 32'h0000_9999, 1'b0, 4'hC, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_0208, 32'h0000_0055, 4'h3, 3'd5, 2, 32'h0000_7777, 1'b1, 4'h3, 32'hDEAD_BEEF, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hA, 3'd7, 0, 32'hCAFE_F00D, 1'b0, 4'h0, 32'hCAFE_F00D, 1'b0};

    rst = 1'b1;
    pselxM = 1'b0; pwriteM = 1'b0; paddrM = '0; pwdataM = '0; pstrbM = '0; pprotM = '0;
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_preadyM", preadyM, 1'b0);
    chk("rst_prdataM", prdataM, '0);
    chk("rst_pslverrM", pslverrM, 1'b0);
    chk("rst_bus", bus_now, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i], 1'b0, lat);
      if (i == 0) chk("idle_to_setup_latency", lat, 1);
      wait_done();
    end
    last_rd = 32'hCAFE_F00D;

    // Back-to-back writes with the request held high throughout.
    pulse0 = pulse_cnt;
    issue(mk(1'b1, 32'h10, 32'hA0A0_0010, 4'hF, 3'd0, 0, 32'h0, 1'b0, last_rd), 1'b1, lat);
    idle0 = idle_cyc;
    issue(mk(1'b1, 32'h20, 32'hA0A0_0020, 4'h5, 3'd1, 1, 32'h0, 1'b0, last_rd), 1'b1, lat);
    issue(mk(1'b1, 32'h30, 32'hA0A0_0030, 4'hF, 3'd0, 0, 32'h0, 1'b1, last_rd), 1'b0, lat);
    chk("b2b_idle_cycles", idle_cyc - idle0, 0);
    wait_done();
    chk("b2b_pulses", pulse_cnt - pulse0, 3);

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never answers: forced error completion, prdataM unchanged.
    v = mk(1'b0, 32'h40, 32'h0, 4'hF, 3'd0, 1000, 32'h5555_5555, 1'b0, last_rd);
    v.exp_err = 1'b1;
    issue(v, 1'b0, lat);
    wait_done();
    resp_q.delete();
    chk("timeout_back_to_idle", psel, 1'b0);
`endif

    // Abort a read stuck in ACCESS with an asynchronous reset.
    v = mk(1'b0, 32'h80, 32'h0, 4'hF, 3'd1, 50, 32'h6666_6666, 1'b0, last_rd);
    issue(v, 1'b0, lat);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_access", penable, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_psel", psel, 1'b0);
    chk("async_rst_penable", penable, 1'b0);
    chk("async_rst_preadyM", preadyM, 1'b0);
    chk("async_rst_prdataM", prdataM, '0);
    chk("async_rst_paddr", paddr, '0);
    exp_q.delete(); resp_q.delete(); bus_q.delete();
    cur_bus = '0; acc_run = 0;
    pulse0 = pulse_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_pulse_after_abort", pulse_cnt - pulse0, 0);
    issue(mk(1'b1, 32'h84, 32'h0000_ABCD, 4'hF, 3'd0, 0, 32'h0, 1'b0, 32'h0), 1'b0, lat);
    chk("post_reset_setup_latency", lat, 1);
    wait_done();
    chk("post_reset_pulse", pulse_cnt - pulse0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_apb_master
